twiddle_gen: RTL

//  Reader/consumer of the quarter-wave cosine twiddle ROM (twrom). Accepts a full twiddle index k.

---
 rtl/twiddle_pkg.sv | 19 +
 rtl/twiddle_fold.sv | 50 +++++
 rtl/twiddle_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/twiddle_pkg.sv
// Shared types and default sizes for the twiddle-factor generator.
// The quarter-wave cosine ROM holds N/4 unsigned magnitudes; entry 0 is 2^(TW_W-1).
package twiddle_pkg;

    localparam int NFFT_LOG2_DEF = 10;
    localparam int TW_W_DEF      = 16;
    localparam int OUT_W_DEF     = TW_W_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_C,
        ST_ISSUE_S,
        ST_LAST,
        ST_HOLD
    } state_t;

    typedef logic [1:0] quad_t;

endpackage

// File: rtl/twiddle_fold.sv
// Quadrant folding: maps (q, C, S) magnitudes onto signed W^k = cos - j*sin.
// The magnitudes are zero-extended by one bit so that +/-2^(TW_W-1) is exact.
module twiddle_fold
    import twiddle_pkg::*;
#(
    parameter int TW_W  = TW_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  quad_t                    i_q,
    input  logic [TW_W-1:0]          i_c,
    input  logic [TW_W-1:0]          i_s,
    output logic signed [OUT_W-1:0]  o_re,
    output logic signed [OUT_W-1:0]  o_im
);

    logic signed [OUT_W-1:0] w_c_pos;
    logic signed [OUT_W-1:0] w_c_neg;
    logic signed [OUT_W-1:0] w_s_pos;
    logic signed [OUT_W-1:0] w_s_neg;

    assign w_c_pos = $signed({{(OUT_W-TW_W){1'b0}}, i_c});
    assign w_s_pos = $signed({{(OUT_W-TW_W){1'b0}}, i_s});
    assign w_c_neg = -w_c_pos;
    assign w_s_neg = -w_s_pos;

    // im is -sin, so each quadrant's sin term appears negated here.
    always_comb begin
        o_re = w_c_pos;
        o_im = w_s_neg;
        case (i_q)
            2'd0: begin
                o_re = w_c_pos;
                o_im = w_s_neg;
            end
            2'd1: begin
                o_re = w_s_neg;
                o_im = w_c_neg;
            end
            2'd2: begin
                o_re = w_c_neg;
                o_im = w_s_pos;
            end
            default: begin
                o_re = w_s_pos;
                o_im = w_c_pos;
            end
        endcase
    end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle generator: two sequential reads of the quarter-wave cosine ROM (C then S),
// folded by quadrant into W^k = exp(-j*2*pi*k/N), returned over a valid/ready pair.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
    parameter int TW_W      = TW_W_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NFFT_LOG2-1:0]     req_k,
    output logic                     twact,
    output logic [NFFT_LOG2-3:0]     twa,
    input  logic [TW_W-1:0]          twdr_cos,
    output logic                     tw_valid,
    input  logic                     tw_ready,
    output logic signed [OUT_W-1:0]  tw_re,
    output logic signed [OUT_W-1:0]  tw_im
);

    localparam int AW = NFFT_LOG2 - 2;

    state_t                   r_state;
    quad_t                    r_q;
    logic [AW-1:0]            r_r;
    logic                     r_rzero;
    logic [TW_W-1:0]          r_c;
    logic                     r_twact;
    logic [AW-1:0]            r_twa;
    logic                     r_valid;
    logic signed [OUT_W-1:0]  r_re;
    logic signed [OUT_W-1:0]  r_im;

    logic [AW-1:0]            w_sin_addr;
    logic [TW_W-1:0]          w_s;
    logic signed [OUT_W-1:0]  w_re;
    logic signed [OUT_W-1:0]  w_im;

    // N/4 - r modulo the ROM depth is simply the two's complement of r.
    assign w_sin_addr = ~r_r + {{(AW-1){1'b0}}, 1'b1};
    assign w_s        = r_rzero ? '0 : twdr_cos;

    twiddle_fold #(
        .TW_W  (TW_W),
        .OUT_W (OUT_W)
    ) u_fold (
        .i_q  (r_q),
        .i_c  (r_c),
        .i_s  (w_s),
        .o_re (w_re),
        .o_im (w_im)
    );

    // ROM controls are registered one state early so that twact is high
    // during ISSUE_C (cos read) and, unless r==0, during ISSUE_S (sin read).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_rzero <= 1'b0;
            r_c     <= '0;
            r_twact <= 1'b0;
            r_twa   <= '0;
            r_valid <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_q     <= req_k[NFFT_LOG2-1:NFFT_LOG2-2];
                        r_r     <= req_k[AW-1:0];
                        r_rzero <= (req_k[AW-1:0] == '0);
                        r_twact <= 1'b1;
                        r_twa   <= req_k[AW-1:0];
                        r_state <= ST_ISSUE_C;
                    end
                end
                ST_ISSUE_C: begin
                    r_twact <= !r_rzero;
                    r_twa   <= r_rzero ? '0 : w_sin_addr;
                    r_state <= ST_ISSUE_S;
                end
                ST_ISSUE_S: begin
                    r_c     <= twdr_cos;
                    r_twact <= 1'b0;
                    r_state <= ST_LAST;
                end
                ST_LAST: begin
                    r_re    <= w_re;
                    r_im    <= w_im;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (tw_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_twact <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign twact     = r_twact;
    assign twa       = r_twa;
    assign tw_valid  = r_valid;
    assign tw_re     = r_re;
    assign tw_im     = r_im;

endmodule
